control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter INST_ADDR_WIDTH, default 8, instruction address width.
REQ-002 SHALL have parameter DATA_ADDR_WIDTH, default 8, data RAM address width.
REQ-003 SHALL have port i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_inst, input, 16, instruction word from the program counter, valid one cycle after any PC update.
REQ-006 SHALL have port o_pc_inc, output, 1, PC increment strobe.
REQ-007 SHALL have port o_pc_load, output, 1, PC load strobe.
REQ-008 SHALL have port o_pc_addr, output, INST_ADDR_WIDTH, PC load target.
REQ-009 SHALL have port o_ram_load, output, 1, RAM write strobe.
REQ-010 SHALL have port o_ram_addr, output, DATA_ADDR_WIDTH, RAM address.
REQ-011 SHALL have port o_ram_data, output, 16, RAM write data.
REQ-012 SHALL have port i_ram_data, input, 16, RAM read data, valid one cycle after o_ram_addr.
REQ-013 SHALL have port o_acc, output, 16, accumulator value.
REQ-014 SHALL have port o_halted, output, 1, high while in HALT.

Function
REQ-015 SHALL decode opcode = i_inst[15:12] and operand = i_inst[7:0].
REQ-016 Opcodes SHALL be: 0 NOP; 1 LOADI (acc = zero-extended operand); 2 LOAD (acc = ram[operand]); 3 STORE (ram[operand] = acc); 4 ADD (acc = acc + ram[operand], mod 2^16, carry discarded); 5 JMP (PC = operand); 6 JZ (PC = operand if acc == 0, else PC+1); 7 HALT. Opcodes 8-15 SHALL execute as NOP.
REQ-017 FSM states SHALL be BOOT, FETCH, EXEC, MEM, HALT.
REQ-018 BOOT SHALL assert o_pc_load with o_pc_addr = 0 for one cycle, then go to FETCH.
REQ-019 FETCH SHALL assert no strobes for one cycle, then go to EXEC.
REQ-020 EXEC SHALL act on i_inst. NOP, LOADI, STORE, not-taken JZ: assert o_pc_inc, go to FETCH. JMP and taken JZ: assert o_pc_load, go to FETCH. LOAD and ADD: drive o_ram_addr, go to MEM. HALT: go to HALT with no PC strobe.
REQ-021 STORE SHALL assert o_ram_load for exactly the EXEC cycle, with o_ram_addr = operand and o_ram_data = acc.
REQ-022 MEM SHALL hold o_ram_addr, update acc from i_ram_data, assert o_pc_inc, and go to FETCH.
REQ-023 Instruction latency: 2 cycles for NOP, LOADI, STORE, JMP and JZ; 3 cycles for LOAD and ADD.
REQ-024 o_pc_inc and o_pc_load SHALL never be high in the same cycle.
REQ-025 HALT SHALL be absorbing until i_reset, with all strobes low and acc held.
REQ-026 Branch target SHALL be operand[INST_ADDR_WIDTH-1:0]; operand bits above INST_ADDR_WIDTH SHALL be ignored.
REQ-027 RAM address SHALL be operand[DATA_ADDR_WIDTH-1:0]; operand bits above DATA_ADDR_WIDTH SHALL be ignored.
REQ-028 PC wrap at the top address SHALL be left to the program counter; the control unit SHALL not special-case it.

Reset
REQ-029 While i_reset is high, o_ram_load, o_pc_inc and o_pc_load SHALL be forced low combinationally; a STORE in progress SHALL be aborted with no write.
REQ-030 The next state after reset SHALL be BOOT, with acc = 0, o_halted = 0 and o_ram_addr = 0, from any state including MEM and HALT.

Configuration
REQ-031 With macro CONTROL_UNIT_RETIRE_COUNT_EN defined, the block SHALL add output o_retired, 16 bits, counting completed instructions (HALT excluded). It SHALL reset to 0 and saturate at 0xFFFF.
REQ-032 Without CONTROL_UNIT_RETIRE_COUNT_EN, the port and its counter SHALL be absent.

Structure
REQ-033 Opcode constants, the FSM state encoding and OPCODE_WIDTH = 4 SHALL live in shared package cr_cpu_pkg.
REQ-034 Opcode decode SHALL be a combinational sub-module cu_decode, with outputs is_mem_read, is_store, is_jump, is_cond and is_halt.

Verification
REQ-035 Reset then program {LOADI 5; HALT} -> o_pc_load at cycle 1 with address 0; acc = 5 after the first EXEC; o_halted = 1 and no strobes thereafter.
REQ-036 ram[3] = 0xFFFF, program {LOADI 2; ADD 3; STORE 4; HALT} -> acc = 0x0001 (wrap); one-cycle o_ram_load with addr 4, data 0x0001.
REQ-037 Program {LOADI 0; JZ 6} -> o_pc_load with o_pc_addr = 6. {LOADI 1; JZ 6} -> o_pc_inc and no load.
REQ-038 Assert i_reset during the STORE EXEC cycle -> o_ram_load stays 0, next state BOOT, acc = 0.
REQ-039 Opcode 0xF -> behaves as NOP (o_pc_inc, acc unchanged). With CONTROL_UNIT_RETIRE_COUNT_EN, o_retired increments by 1 per instruction.

Source files
------------

// File: rtl/cr_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode constants, opcode
// width and the control-unit FSM state encoding.
package cr_cpu_pkg;

  localparam int unsigned OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOADI = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ    = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 4'd7;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier for the control unit. Unlisted opcodes
// (NOP and 8-15) leave every class flag low and therefore execute as NOP.
module cu_decode
  import cr_cpu_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output logic                    o_is_mem_read,
  output logic                    o_is_store,
  output logic                    o_is_jump,
  output logic                    o_is_cond,
  output logic                    o_is_halt,
  output logic                    o_is_loadi,
  output logic                    o_is_add
);

  // Map each opcode onto its instruction-class flags.
  always_comb begin
    o_is_mem_read = 1'b0;
    o_is_store    = 1'b0;
    o_is_jump     = 1'b0;
    o_is_cond     = 1'b0;
    o_is_halt     = 1'b0;
    o_is_loadi    = 1'b0;
    o_is_add      = 1'b0;
    case (i_opcode)
      OP_LOADI: o_is_loadi = 1'b1;
      OP_LOAD:  o_is_mem_read = 1'b1;
      OP_STORE: o_is_store = 1'b1;
      OP_ADD: begin
        o_is_mem_read = 1'b1;
        o_is_add      = 1'b1;
      end
      OP_JMP:   o_is_jump = 1'b1;
      OP_JZ: begin
        o_is_jump = 1'b1;
        o_is_cond = 1'b1;
      end
      OP_HALT:  o_is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit for a 16-bit accumulator CPU: BOOT -> FETCH -> EXEC [-> MEM].
// Optional macro CONTROL_UNIT_RETIRE_COUNT_EN adds o_retired, a saturating
// count of completed instructions (HALT not counted).
module control_unit
  import cr_cpu_pkg::*;
#(
  parameter int unsigned INST_ADDR_WIDTH = 8,
  parameter int unsigned DATA_ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [15:0]                i_inst,
  output logic                       o_pc_inc,
  output logic                       o_pc_load,
  output logic [INST_ADDR_WIDTH-1:0] o_pc_addr,
  output logic                       o_ram_load,
  output logic [DATA_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [15:0]                o_ram_data,
  input  logic [15:0]                i_ram_data,
  output logic [15:0]                o_acc,
  output logic                       o_halted
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
  ,
  output logic [15:0]                o_retired
`endif
);

  state_t                       r_state;
  state_t                       w_next;
  logic [15:0]                  r_acc;
  logic [DATA_ADDR_WIDTH-1:0]   r_ram_addr;
  logic                         r_mem_add;

  logic [OPCODE_WIDTH-1:0]      w_opcode;
  logic [7:0]                   w_operand;
  logic [INST_ADDR_WIDTH-1:0]   w_target;
  logic [DATA_ADDR_WIDTH-1:0]   w_daddr;
  logic                         w_unused_bits;
  logic                         w_is_mem_read;
  logic                         w_is_store;
  logic                         w_is_jump;
  logic                         w_is_cond;
  logic                         w_is_halt;
  logic                         w_is_loadi;
  logic                         w_is_add;

  assign w_opcode      = i_inst[15:12];
  assign w_operand     = i_inst[7:0];
  assign w_unused_bits = ^i_inst[11:8];
  // Casts drop operand bits above the address width (or zero-extend).
  assign w_target      = INST_ADDR_WIDTH'(w_operand);
  assign w_daddr       = DATA_ADDR_WIDTH'(w_operand);

  cu_decode u_decode (
    .i_opcode      (w_opcode),
    .o_is_mem_read (w_is_mem_read),
    .o_is_store    (w_is_store),
    .o_is_jump     (w_is_jump),
    .o_is_cond     (w_is_cond),
    .o_is_halt     (w_is_halt),
    .o_is_loadi    (w_is_loadi),
    .o_is_add      (w_is_add)
  );

  // State register; reset from any state lands in BOOT.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_BOOT;
    else         r_state <= w_next;
  end

  // Next state and strobes; reset masks every strobe combinationally so an
  // in-flight STORE never reaches the RAM.
  always_comb begin
    w_next     = r_state;
    o_pc_inc   = 1'b0;
    o_pc_load  = 1'b0;
    o_pc_addr  = '0;
    o_ram_load = 1'b0;
    o_ram_addr = r_ram_addr;
    case (r_state)
      ST_BOOT: begin
        o_pc_load = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_FETCH: w_next = ST_EXEC;
      ST_EXEC: begin
        w_next = ST_FETCH;
        if (w_is_halt) begin
          w_next = ST_HALT;
        end else if (w_is_mem_read) begin
          o_ram_addr = w_daddr;
          w_next     = ST_MEM;
        end else if (w_is_jump && (!w_is_cond || (r_acc == '0))) begin
          o_pc_load = 1'b1;
          o_pc_addr = w_target;
        end else begin
          o_pc_inc = 1'b1;
          if (w_is_store) begin
            o_ram_load = 1'b1;
            o_ram_addr = w_daddr;
          end
        end
      end
      ST_MEM: begin
        o_pc_inc = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_BOOT;
    endcase
    if (i_reset) begin
      o_pc_inc   = 1'b0;
      o_pc_load  = 1'b0;
      o_ram_load = 1'b0;
    end
  end

  // Accumulator and held RAM address; MEM remembers whether it is an ADD.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc      <= '0;
      r_ram_addr <= '0;
      r_mem_add  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_ram_addr <= o_ram_addr;
      r_mem_add  <= w_is_add;
      if (w_is_loadi) r_acc <= {8'h00, w_operand};
    end else if (r_state == ST_MEM) begin
      r_acc <= r_mem_add ? (r_acc + i_ram_data) : i_ram_data;
    end
  end

  assign o_ram_data = r_acc;
  assign o_acc      = r_acc;
  assign o_halted   = (r_state == ST_HALT);

`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
  logic [15:0] r_retired;
  logic        w_retire;

  // Plain instructions complete in EXEC; LOAD/ADD complete in MEM.
  assign w_retire = (r_state == ST_MEM) ||
                    ((r_state == ST_EXEC) && !w_is_halt && !w_is_mem_read);

  // Saturating retired-instruction counter.
  always_ff @(posedge i_clk) begin
    if (i_reset)                          r_retired <= '0;
    else if (w_retire && (r_retired != '1)) r_retired <= r_retired + 16'd1;
  end

  assign o_retired = r_retired;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: program-table scoreboard plus
// cycle-accurate sequences for boot, branches, memory latency and reset.
`timescale 1ns/1ps
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst;
  logic        pc_inc, pc_load, ram_load, halted;
  logic [7:0]  pc_addr, ram_addr;
  logic [15:0] ram_data, ram_rd, acc;
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  logic [15:0] rom [256];
  logic [15:0] ram [256];
  logic [7:0]  pc = 8'h00;
  logic        tb_wr = 1'b0;
  logic [7:0]  tb_wa = 8'h00;
  logic [15:0] tb_wd = 16'h0000;

  int tests = 0;
  int fails = 0;
  int overlap = 0;
  logic [23:0] wr_q [$];

  typedef struct {
    string       name;
    logic [15:0] p0, p1, p2, p3, ram3, acc;
    int unsigned ret;
    int unsigned nwr;
    logic [7:0]  wa;
    logic [15:0] wd;
  } vec_t;

  vec_t vecs [9];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  control_unit #(.INST_ADDR_WIDTH(8), .DATA_ADDR_WIDTH(8)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_inst     (inst),
    .o_pc_inc   (pc_inc),
    .o_pc_load  (pc_load),
    .o_pc_addr  (pc_addr),
    .o_ram_load (ram_load),
    .o_ram_addr (ram_addr),
    .o_ram_data (ram_data),
    .i_ram_data (ram_rd),
    .o_acc      (acc),
    .o_halted   (halted)
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
    ,
    .o_retired  (retired)
`endif
  );

  // Program counter, instruction ROM and synchronous-read data RAM.
  assign inst = rom[pc];
  always @(posedge clk) begin
    if (rst)          pc <= 8'h00;
    else if (pc_load) pc <= pc_addr;
    else if (pc_inc)  pc <= pc + 8'd1;
    ram_rd <= ram[ram_addr];
    if (ram_load)   ram[ram_addr] <= ram_data;
    else if (tb_wr) ram[tb_wa] <= tb_wd;
  end

  // Strobe monitor: PC strobe overlap and a log of RAM writes.
  always @(negedge clk) begin
    if (pc_inc && pc_load) overlap++;
    if (ram_load) wr_q.push_back({ram_addr, ram_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [15:0] p0, p1, p2, p3);
    for (int i = 0; i < 256; i++) rom[i] = 16'h7000;
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
  endtask

  task automatic ram_poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk); tb_wr = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk); tb_wr = 1'b0;
  endtask

  // Ends just after the negedge where the DUT sits in BOOT (cycle index 0).
  task automatic start();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
    #1;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  initial begin
    bit ok;
    vec_t e;

    vecs[0] = '{"loadi_halt",   16'h1005, 16'h7000, 16'h7000, 16'h7000, 16'h0000, 16'h0005, 1, 0, 8'h00, 16'h0000};
    vecs[1] = '{"add_wrap",     16'h1002, 16'h4003, 16'h3004, 16'h7000, 16'hFFFF, 16'h0001, 3, 1, 8'h04, 16'h0001};
    vecs[2] = '{"jz_taken",     16'h1000, 16'h6006, 16'h1009, 16'h7000, 16'h0000, 16'h0000, 2, 0, 8'h00, 16'h0000};
    vecs[3] = '{"jz_not_taken", 16'h1001, 16'h6006, 16'h1009, 16'h7000, 16'h0000, 16'h0009, 3, 0, 8'h00, 16'h0000};
    vecs[4] = '{"nop_f_hibits", 16'h1F07, 16'hF0AB, 16'h0000, 16'h7000, 16'h0000, 16'h0007, 3, 0, 8'h00, 16'h0000};
    vecs[5] = '{"store_load",   16'h1003, 16'h3010, 16'h2003, 16'h7000, 16'h1234, 16'h1234, 3, 1, 8'h10, 16'h0003};
    vecs[6] = '{"jmp",          16'h5002, 16'h1001, 16'h102A, 16'h7000, 16'h0000, 16'h002A, 2, 0, 8'h00, 16'h0000};
    vecs[7] = '{"load_add",     16'h2003, 16'h4003, 16'h7000, 16'h7000, 16'h8001, 16'h0002, 2, 0, 8'h00, 16'h0000};
    vecs[8] = '{"jmp_top",      16'h50FF, 16'h1001, 16'h1001, 16'h1001, 16'h0000, 16'h0000, 1, 0, 8'h00, 16'h0000};

    // Boot timing, LOADI, HALT absorption and reset out of HALT.
    load_prog(16'h1005, 16'h7000, 16'h7000, 16'h7000);
    start();
    check("boot_pc_load", pc_load, 1);
    check("boot_pc_addr", pc_addr, 0);
    check("boot_pc_inc", pc_inc, 0);
    check("boot_acc", acc, 0);
    step(); check("fetch_strobes", {pc_inc, pc_load, ram_load}, 3'b000);
    step(); check("loadi_exec_strobes", {pc_inc, pc_load}, 2'b10);
    step(); check("loadi_acc", acc, 16'h0005);
    step(); check("halt_exec_strobes", {pc_inc, pc_load, ram_load, halted}, 4'b0000);
    step(); check("halted", halted, 1);
    for (int i = 0; i < 3; i++) begin
      step(); check("halt_hold", {pc_inc, pc_load, ram_load, halted, acc}, {4'b0001, 16'h0005});
    end
    start();
    check("halt_reset", {halted, pc_load, acc, ram_addr}, {2'b01, 16'h0000, 8'h00});

    // JZ taken / not taken strobes at the second EXEC.
    load_prog(16'h1000, 16'h6006, 16'h7000, 16'h7000);
    start(); repeat (4) step();
    check("jz_taken_strobes", {pc_inc, pc_load, pc_addr}, {2'b01, 8'h06});
    load_prog(16'h1001, 16'h6006, 16'h7000, 16'h7000);
    start(); repeat (4) step();
    check("jz_not_taken_strobes", {pc_inc, pc_load}, 2'b10);

    // STORE aborted by reset during its EXEC cycle.
    rst = 1'b1;
    ram_poke(8'h05, 16'hDEAD);
    load_prog(16'h1033, 16'h3005, 16'h7000, 16'h7000);
    start(); repeat (4) step();
    check("store_exec", {ram_load, ram_addr, ram_data}, {1'b1, 8'h05, 16'h0033});
    rst = 1'b1; #1;
    check("store_abort_mask", {ram_load, pc_inc, pc_load}, 3'b000);
    step(); rst = 1'b0; #1;
    check("store_abort_boot", {pc_load, halted, acc, ram_addr}, {2'b10, 16'h0000, 8'h00});
    check("store_abort_ram", ram[5], 16'hDEAD);

    // LOAD latency, held address, and reset out of MEM.
    rst = 1'b1;
    ram_poke(8'h03, 16'hABCD);
    load_prog(16'h2003, 16'h7000, 16'h7000, 16'h7000);
    start(); repeat (2) step();
    check("load_exec", {pc_inc, pc_load, ram_addr}, {2'b00, 8'h03});
    step(); check("load_mem", {pc_inc, pc_load, ram_addr}, {2'b10, 8'h03});
    step(); check("load_acc", acc, 16'hABCD);
    start(); repeat (3) step();
    rst = 1'b1; #1;
    check("mem_reset_mask", {pc_inc, pc_load, ram_load}, 3'b000);
    step(); rst = 1'b0; #1;
    check("mem_reset_boot", {pc_load, acc, ram_addr}, {1'b1, 16'h0000, 8'h00});

    // Program table through the scoreboard.
    for (int v = 0; v < 9; v++) begin
      rst = 1'b1;
      load_prog(vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3);
      ram_poke(8'h03, vecs[v].ram3);
      exp_q.push_back(vecs[v]);
      start();
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
        if (halted) ok = 1'b1;
        else step();
      end
      e = exp_q.pop_front();
      check($sformatf("%s_halt_reached", e.name), ok, 1);
      check($sformatf("%s_acc", e.name), acc, e.acc);
      check($sformatf("%s_writes", e.name), wr_q.size(), e.nwr);
      if (e.nwr != 0 && wr_q.size() != 0)
        check($sformatf("%s_write", e.name), wr_q[0], {e.wa, e.wd});
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
      check($sformatf("%s_retired", e.name), retired, e.ret);
`endif
    end

    check("pc_inc_load_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
